// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending front-end: line count, code
// width, controller state encoding and the code-to-mask helper.
package irq_pkg;

  localparam int N      = 8;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OFFER = 2'b01,
    GAP   = 2'b10
  } irq_state_e;

  // Convert an encoder code into the one-hot mask of the line it names.
  function automatic logic [N-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [N-1:0] m;
    m = {{(N-1){1'b0}}, 1'b1} << code;
    return m;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the raw request lines.
// Build option IRQ_SYNC_EN: when defined, req_in passes through a 2-flop
// synchronizer first (adds two cycles of latency); otherwise req_in must
// already be synchronous to clk.
module irq_edge_detect
  import irq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] rise
);

  logic [N-1:0] req_s;
  logic [N-1:0] req_prev_r;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync1_r;
  logic [N-1:0] sync2_r;

  // Two-stage synchronizer bringing asynchronous requests into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {N{1'b0}};
      sync2_r <= {N{1'b0}};
    end else begin
      sync1_r <= req_in;
      sync2_r <= sync1_r;
    end
  end

  assign req_s = sync2_r;
`else
  assign req_s = req_in;
`endif

  // Remember last cycle's level so a held line only produces one rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev_r <= {N{1'b0}};
    end else begin
      req_prev_r <= req_s;
    end
  end

  assign rise = req_s & ~req_prev_r;

endmodule

// File: rtl/irq_prio_enc.sv
// 8-input priority encoder: bit 0 has the highest priority. An all-zero input
// yields code 0; the controller never samples the code in that case.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [N-1:0]      req,
  output logic [CODE_W-1:0] code
);

  // Scan from the lowest-priority line upward so the lowest set index wins.
  always_comb begin
    code = {CODE_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      code = req[i] ? CODE_W'(i) : code;
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt request front-end: latches request edges into a pending register,
// exposes pending & mask to an external priority encoder, captures the
// winning code, and offers it to the consumer over valid/ready.
// Build option IRQ_SYNC_EN enables the request synchronizer (see
// irq_edge_detect).
module irq_pending_ctrl
  import irq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_in,
  input  logic [N-1:0]      mask,
  input  logic              clr_all,
  output logic [N-1:0]      pend_vec,
  input  logic [CODE_W-1:0] enc_code,
  output logic              irq_valid,
  output logic [CODE_W-1:0] irq_code,
  input  logic              irq_ready,
  output logic              busy
);

  irq_state_e   state_r;
  irq_state_e   state_nxt_s;
  logic [N-1:0] pending_r;
  logic [N-1:0] pending_nxt_s;
  logic [N-1:0] rise_s;
  logic [N-1:0] clr_mask_s;
  logic         capture_s;

  irq_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_in (req_in),
    .rise   (rise_s)
  );

  // Masked lines stay pending but are hidden from the encoder.
  assign pend_vec = pending_r & mask;

  assign busy = (state_r != IDLE);

  // Next-state logic; capture only when something is visible, since the
  // encoder code is meaningless for an all-zero input.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (|pend_vec) begin
          state_nxt_s = OFFER;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OFFER: begin
        if (irq_ready) begin
          state_nxt_s = GAP;
        end else begin
          state_nxt_s = OFFER;
        end
      end
      GAP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Pending update: a same-cycle edge beats both the global and the grant clear.
  always_comb begin
    clr_mask_s    = {N{1'b0}};
    pending_nxt_s = pending_r;
    if (capture_s) begin
      clr_mask_s = onehot(enc_code);
    end else begin
      clr_mask_s = {N{1'b0}};
    end
    if (clr_all) begin
      pending_nxt_s = rise_s;
    end else begin
      pending_nxt_s = (pending_r & ~clr_mask_s) | rise_s;
    end
  end

  // State and pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pending_r <= {N{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  // Registered handshake outputs; the code is frozen for the whole offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_valid <= 1'b0;
      irq_code  <= {CODE_W{1'b0}};
    end else begin
      irq_valid <= (state_nxt_s == OFFER);
      if (capture_s) begin
        irq_code <= enc_code;
      end else begin
        irq_code <= irq_code;
      end
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl with the priority encoder attached.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       clr_all;
  logic       irq_ready;
  logic [7:0] pend_vec;
  logic [2:0] enc_code;
  logic       irq_valid;
  logic [2:0] irq_code;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

`ifdef IRQ_SYNC_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 2;
`endif

  // Reference model state, kept in spec terms: pending set, edge history,
  // offer phase (0 idle, 1 offering, 2 gap) and last granted code.
  logic [7:0] m_pend, m_prev, m_s1, m_s2;
  int         m_phase;
  logic [2:0] m_code;

  // Handshakes actually observed on the DUT outputs.
  int   gl_code[$];
  int   gl_cyc[$];
  logic hs_valid;
  logic [2:0] hs_code;

  always #5 clk = ~clk;

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .clr_all   (clr_all),
    .pend_vec  (pend_vec),
    .enc_code  (enc_code),
    .irq_valid (irq_valid),
    .irq_code  (irq_code),
    .irq_ready (irq_ready),
    .busy      (busy)
  );

  irq_prio_enc u_enc (
    .req  (pend_vec),
    .code (enc_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 8'h00; m_prev = 8'h00; m_s1 = 8'h00; m_s2 = 8'h00;
    m_phase = 0; m_code = 3'd0; hs_valid = 1'b0; hs_code = 3'd0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, irq_valid, (m_phase == 1));
    chk({tag, "_code"},  irq_code,  m_code);
    chk({tag, "_busy"},  busy,      (m_phase != 0));
    chk({tag, "_pend"},  pend_vec,  m_pend & mask);
  endtask

  // One clock: log the DUT handshake, advance the model, then compare.
  task automatic tick();
    logic [7:0] req_s, rise, vis, clr;
    int win;
    @(posedge clk);
    cyc++;
    if (hs_valid && irq_ready) begin
      gl_code.push_back(int'(hs_code));
      gl_cyc.push_back(cyc);
    end
`ifdef IRQ_SYNC_EN
    req_s = m_s2; m_s2 = m_s1; m_s1 = req_in;
`else
    req_s = req_in;
`endif
    rise   = req_s & ~m_prev;
    m_prev = req_s;
    vis    = m_pend & mask;
    clr    = 8'h00;
    if (m_phase == 0) begin
      if (vis != 8'h00) begin
        win = 0;
        for (int i = 7; i >= 0; i--) if (vis[i]) win = i;
        m_code  = 3'(win);
        clr     = 8'h01 << win;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (irq_ready) m_phase = 2;
    end else begin
      m_phase = 0;
    end
    m_pend = clr_all ? rise : ((m_pend & ~clr) | rise);
    #1;
    check_outputs("cyc");
    hs_valid = irq_valid;
    hs_code  = irq_code;
  endtask

  task automatic clear_log();
    gl_code.delete();
    gl_cyc.delete();
  endtask

  function automatic int log_code(input int i);
    return (i < gl_code.size()) ? gl_code[i] : -1;
  endfunction

  function automatic int log_gap(input int i);
    return (i + 1 < gl_cyc.size()) ? (gl_cyc[i+1] - gl_cyc[i]) : -1;
  endfunction

  task automatic run_t1(input string tag);
    int lat;
    irq_ready = 1'b1;
    req_in = 8'h04;
    tick();
    req_in = 8'h00;
    lat = 1;
    while (!irq_valid && lat < 12) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, EXP_LAT);
    chk({tag, "_code"}, irq_code, 32'd2);
    chk({tag, "_pend0"}, pend_vec, 32'h00);
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; req_in = 8'h00; mask = 8'hFF; clr_all = 1'b0; irq_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_valid", irq_valid, 32'd0);
    chk("rst_code",  irq_code,  32'd0);
    chk("rst_busy",  busy,      32'd0);
    chk("rst_pend",  pend_vec,  32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    // Test 1: single pulse on line 2.
    run_t1("t1");

    // Test 2: three simultaneous requests drain in priority order.
    clear_log();
    req_in = 8'b1001_0010;
    tick();
    req_in = 8'h00;
    repeat (12) tick();
    chk("t2_n", gl_code.size(), 32'd3);
    chk("t2_g0", log_code(0), 32'd1);
    chk("t2_g1", log_code(1), 32'd4);
    chk("t2_g2", log_code(2), 32'd7);
    chk("t2_sp0", log_gap(0), 32'd3);
    chk("t2_sp1", log_gap(1), 32'd3);
    chk("t2_valid", irq_valid, 32'd0);
    chk("t2_busy", busy, 32'd0);

    // Test 3: a held line grants once.
    clear_log();
    req_in = 8'h08;
    repeat (20) tick();
    req_in = 8'h00;
    repeat (4) tick();
    chk("t3_n", gl_code.size(), 32'd1);
    chk("t3_g0", log_code(0), 32'd3);

    // Test 4: masked line stays pending, appears when unmasked.
    clear_log();
    mask = 8'hFE;
    req_in = 8'h21;
    tick();
    req_in = 8'h00;
    repeat (6) tick();
    chk("t4_n", gl_code.size(), 32'd1);
    chk("t4_g0", log_code(0), 32'd5);
    chk("t4_hidden", pend_vec, 32'h00);
    mask = 8'hFF;
    #1;
    chk("t4_unmask", pend_vec, 32'h01);
    repeat (5) tick();
    chk("t4_n2", gl_code.size(), 32'd2);
    chk("t4_g1", log_code(1), 32'd0);

    // Test 5: stalled offer holds; clr_all clears others but not the offer.
    clear_log();
    irq_ready = 1'b0;
    req_in = 8'h40;
    tick();
    req_in = 8'h00;
    tick();
    req_in = 8'h06;
    tick();
    req_in = 8'h00;
    chk("t5_pend_before", pend_vec, 32'h06);
    for (int i = 0; i < 10; i++) begin
      clr_all = (i == 4);
      tick();
      chk("t5_hold_valid", irq_valid, 32'd1);
      chk("t5_hold_code", irq_code, 32'd6);
    end
    clr_all = 1'b0;
    chk("t5_pend_after", pend_vec, 32'h00);
    irq_ready = 1'b1;
    repeat (4) tick();
    chk("t5_n", gl_code.size(), 32'd1);
    chk("t5_g0", log_code(0), 32'd6);
    chk("t5_busy", busy, 32'd0);

    // Test 6: asynchronous reset during an offer.
    irq_ready = 1'b0;
    req_in = 8'h08;
    tick();
    req_in = 8'h00;
    tick();
    req_in = 8'h10;
    tick();
    req_in = 8'h00;
    chk("t6_offer", irq_valid, 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_valid", irq_valid, 32'd0);
    chk("t6_busy", busy, 32'd0);
    chk("t6_pend", pend_vec, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6_quiet", irq_valid, 32'd0);
    run_t1("t6r");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req_in    = 8'($urandom) & 8'($urandom);
      mask      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      irq_ready = ($urandom_range(0, 3) != 0);
      clr_all   = ($urandom_range(0, 15) == 0);
      tick();
    end
    req_in = 8'h00; mask = 8'hFF; clr_all = 1'b0; irq_ready = 1'b1;
    repeat (30) tick();
    chk("end_idle", busy, 32'd0);
    chk("end_pend", pend_vec, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
